// File: rtl/shift_pkg.sv
// Shared opcodes and FSM state encoding for the iterative shifter.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One log2 stage: shift or rotate by 2^amt_sel, selected by op.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt_sel,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    logic [SHW-1:0] s;
    logic [SHW:0]   rs;

    assign s  = SHW'(1) << amt_sel;
    assign rs = (SHW+1)'(WIDTH) - {1'b0, s};

    always_comb begin
        y = a;
        unique case (1'b1)
            op == OP_SLL: y = a << s;
            op == OP_SRL: y = a >> s;
            op == OP_SRA: y = $signed(a) >>> s;
            op == OP_ROL: y = (a << s) | (a >> rs);
            default:      y = a;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one binary-weighted stage per clock,
// optional early exit once no higher shift bits remain.
module iter_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  bit EARLY_EXIT = 1'b0,
    localparam int SHW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             out_en,
    output logic [WIDTH-1:0] out
);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic [SHW-1:0]   b_r, b_n;
    logic [1:0]       op_r, op_n;
    logic [SHW-1:0]   stage, stage_n;
    logic [WIDTH-1:0] out_n;
    logic             out_en_n;

    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] step;
    logic [SHW-1:0]   hi_rem;
    logic             last;

    shift_stage #(.WIDTH(WIDTH)) u_stage (
        .a       (a_r),
        .amt_sel (stage),
        .op      (op_r),
        .y       (y)
    );

    assign step   = b_r[stage] ? y : a_r;
    // Shift-amount bits above the stage being processed now.
    assign hi_rem = (b_r >> stage) >> 1;
    assign last   = (stage == SHW'(SHW-1)) ||
                    (EARLY_EXIT && (hi_rem == '0));
    assign busy   = (state == ST_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            stage  <= '0;
            out    <= '0;
            out_en <= 1'b0;
        end else begin
            state  <= state_n;
            a_r    <= a_n;
            b_r    <= b_n;
            op_r   <= op_n;
            stage  <= stage_n;
            out    <= out_n;
            out_en <= out_en_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a_r;
        b_n      = b_r;
        op_n     = op_r;
        stage_n  = stage;
        out_n    = out;
        out_en_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_en) begin
                    a_n     = a;
                    b_n     = b;
                    op_n    = op;
                    stage_n = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_n     = step;
                stage_n = stage + SHW'(1);
                if (last) begin
                    out_n    = step;
                    out_en_n = 1'b1;
                    stage_n  = '0;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
